// File: rtl/scrambler_ctrl_pkg.sv
// Shared constants, FSM state type and lane geometry for the scrambler control path.
package scrambler_pkg;
   localparam int NUM_LANES = 4;
   localparam int VEC_W     = 8;

   localparam logic [VEC_W-1:0] K_COM = 8'hBC;
   localparam logic [VEC_W-1:0] K_SKP = 8'h1C;

   localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hFFFF;

   typedef enum logic [1:0] {IDLE, TS1W, TS2W, TS3W} scr_state_e;
endpackage

// File: rtl/scrambler_ctrl_os_detect.sv
// Combinational per-lane COM/SKP classification of one word.
module os_detect
   import scrambler_pkg::*;
#(
   parameter int LANES = NUM_LANES,
   parameter int W     = VEC_W
) (
   input  logic [LANES-1:0][W-1:0] data_i,
   input  logic [LANES-1:0]        datak_i,
   output logic [LANES-1:0]        com_o,
   output logic [LANES-1:0]        skp_o
);
   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign com_o[g] = datak_i[g] & (data_i[g] == K_COM);
      assign skp_o[g] = datak_i[g] & (data_i[g] == K_SKP);
   end
endmodule

// File: rtl/scrambler_ctrl.sv
// Ordered-set tracker ahead of the scrambler: one output register stage with per-word control.
// Optional SCR_CTRL_STATS_EN adds saturating TS word-0 / SKP counters.
module scrambler_ctrl
   import scrambler_pkg::*;
#(
   parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [31:0] indata_i,
   input  logic [3:0]  datak_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] data_o,
   output logic [3:0]  datak_o,
   output logic [3:0]  training_sequence_o,
   output logic [1:0]  data_len_o,
   output logic        lfsr_init_o,
   output logic        lfsr_hold_o,
   output logic        scr_disable_o,
   output logic        err_o
`ifdef SCR_CTRL_STATS_EN
   ,
   output logic [15:0] ts_cnt_o,
   output logic [15:0] skp_cnt_o
`endif
);
   // The seed itself is consumed by the scrambler; an all-zero seed would lock its LFSR.
   if (LFSR_SEED == 16'h0) begin : g_zero_seed
   end

   logic [NUM_LANES-1:0] com, skp;
   scr_state_e           state, nxt_state;
   logic [3:0]           nxt_ts;
   logic                 nxt_init, nxt_hold, nxt_err, ld_dis, is_ts0, is_skp;
   logic                 init_q, hold_q, accept;

   os_detect #(.LANES(NUM_LANES), .W(VEC_W)) u_os_detect (
      .data_i (indata_i),
      .datak_i(datak_i),
      .com_o  (com),
      .skp_o  (skp)
   );

   assign in_ready_o  = !out_valid_o | out_ready_i;
   assign accept      = in_valid_i & in_ready_o;
   assign data_len_o  = 2'b10;
   assign lfsr_init_o = out_valid_o & init_q;
   assign lfsr_hold_o = out_valid_o & hold_q;

   // A misplaced COM wins over everything; a lane-0 COM always restarts as if from IDLE.
   always_comb begin
      nxt_state = state;
      nxt_ts    = datak_i;
      nxt_init  = 1'b0;
      nxt_hold  = 1'b0;
      nxt_err   = 1'b0;
      ld_dis    = 1'b0;
      is_ts0    = 1'b0;
      is_skp    = 1'b0;
      if (|com[NUM_LANES-1:1]) begin
         nxt_err   = 1'b1;
         nxt_state = IDLE;
      end else if (com[0]) begin
         nxt_err  = (state != IDLE);
         nxt_ts   = '1;
         nxt_init = 1'b1;
         if (skp[1]) begin
            nxt_hold  = 1'b1;
            nxt_state = IDLE;
            is_skp    = 1'b1;
         end else begin
            nxt_state = TS1W;
            is_ts0    = 1'b1;
         end
      end else begin
         case (state)
            TS1W: begin nxt_ts = '1; ld_dis = 1'b1; nxt_state = TS2W; end
            TS2W: begin nxt_ts = '1; nxt_state = TS3W; end
            TS3W: begin nxt_ts = '1; nxt_state = IDLE; end
            default: nxt_state = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state               <= IDLE;
         out_valid_o         <= 1'b0;
         data_o              <= '0;
         datak_o             <= '0;
         training_sequence_o <= '0;
         init_q              <= 1'b0;
         hold_q              <= 1'b0;
         scr_disable_o       <= 1'b0;
         err_o               <= 1'b0;
      end else begin
         err_o <= accept & nxt_err;
         if (in_ready_o) out_valid_o <= in_valid_i;
         if (accept) begin
            state               <= nxt_state;
            data_o              <= indata_i;
            datak_o             <= datak_i;
            training_sequence_o <= nxt_ts;
            init_q              <= nxt_init;
            hold_q              <= nxt_hold;
            if (ld_dis) scr_disable_o <= indata_i[11];
         end
      end
   end

`ifdef SCR_CTRL_STATS_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ts_cnt_o  <= '0;
         skp_cnt_o <= '0;
      end else begin
         if (accept && is_ts0 && ts_cnt_o != 16'hFFFF)   ts_cnt_o  <= ts_cnt_o + 16'd1;
         if (accept && is_skp && skp_cnt_o != 16'hFFFF)  skp_cnt_o <= skp_cnt_o + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_scrambler_ctrl.sv
// Directed and randomized bench for scrambler_ctrl against an ordered-set position model.
module tb_scrambler_ctrl;
   logic        clk = 1'b0;
   logic        rst_i = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
   logic [31:0] indata = '0;
   logic [3:0]  datak = '0;
   logic        in_ready, out_valid, linit, lhold, sdis, err;
   logic [31:0] data;
   logic [3:0]  dk, ts;
   logic [1:0]  dlen;
`ifdef SCR_CTRL_STATS_EN
   logic [15:0] ts_cnt, skp_cnt;
`endif

   int errors = 0, checks = 0;

   // Model: position inside a 4-word ordered set (0 = outside one) plus the predicted output word.
   logic        m_ov, m_init, m_hold, m_dis, m_err;
   logic [31:0] m_data;
   logic [3:0]  m_k, m_ts;
   int          m_pos, m_tsc, m_skc;

   always #5 clk = ~clk;

   scrambler_ctrl dut (
      .clk_i(clk), .rst_i(rst_i),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .indata_i(indata), .datak_i(datak),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .data_o(data), .datak_o(dk), .training_sequence_o(ts), .data_len_o(dlen),
      .lfsr_init_o(linit), .lfsr_hold_o(lhold), .scr_disable_o(sdis), .err_o(err)
`ifdef SCR_CTRL_STATS_EN
      , .ts_cnt_o(ts_cnt), .skp_cnt_o(skp_cnt)
`endif
   );

   task automatic model_word(input logic [31:0] d, input logic [3:0] k);
      logic com_hi = 1'b0;
      logic com0 = k[0] && d[7:0] == 8'hBC;
      logic skp1 = k[1] && d[15:8] == 8'h1C;
      for (int i = 1; i < 4; i++) if (k[i] && d[8*i +: 8] == 8'hBC) com_hi = 1'b1;
      m_data = d; m_k = k; m_init = 1'b0; m_hold = 1'b0;
      if (com_hi) begin
         m_err = 1'b1; m_ts = k; m_pos = 0;
      end else if (com0) begin
         m_err = (m_pos != 0); m_ts = 4'hF; m_init = 1'b1;
         if (skp1) begin m_hold = 1'b1; m_pos = 0; if (m_skc < 65535) m_skc++; end
         else begin m_pos = 1; if (m_tsc < 65535) m_tsc++; end
      end else if (m_pos == 0) begin
         m_ts = k;
      end else begin
         m_ts = 4'hF;
         if (m_pos == 1) m_dis = d[11];
         m_pos = (m_pos + 1) % 4;
      end
   endtask

   // One clock: present inputs at negedge, advance the model, return just after the posedge.
   task automatic drive(input logic r, input logic v, input logic [31:0] d, input logic [3:0] k,
                        input logic rdy);
      logic acc;
      @(negedge clk);
      rst_i = r; in_valid = v; indata = d; datak = k; out_ready = rdy;
      if (r) begin
         m_ov = 0; m_init = 0; m_hold = 0; m_dis = 0; m_err = 0;
         m_data = '0; m_k = '0; m_ts = '0; m_pos = 0; m_tsc = 0; m_skc = 0;
      end else begin
         acc = v && (!m_ov || rdy);
         m_err = 1'b0;
         if (acc) model_word(d, k);
         if (!m_ov || rdy) m_ov = v;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      drive(1, 1, $urandom, 4'hF, 1);
      drive(1, 1, 32'h000000BC, 4'h1, 1);
      checks++;
      if ({out_valid, data, dk, ts, linit, lhold, sdis, err} !== 44'h0) begin
         errors++;
         $display("FAIL reset_state: got %h want 0", {out_valid, data, dk, ts, linit, lhold, sdis, err});
      end
      checks++;
      if (in_ready !== 1'b1 || dlen !== 2'b10) begin
         errors++; $display("FAIL reset_ready_len: got %b/%b want 1/10", in_ready, dlen);
      end
`ifdef SCR_CTRL_STATS_EN
      checks++;
      if ({ts_cnt, skp_cnt} !== 32'h0) begin
         errors++; $display("FAIL reset_stats: got %h want 0", {ts_cnt, skp_cnt});
      end
`endif
   endtask

   task automatic test_skp;
      drive(0, 1, 32'h1C1C1CBC, 4'hF, 1);
      checks++;
      if ({out_valid, ts, linit, lhold, err} !== 8'b1_1111_1_1_0) begin
         errors++; $display("FAIL skp_word: got %b want 11111110", {out_valid, ts, linit, lhold, err});
      end
      drive(0, 0, 32'h0, 4'h0, 1);
      checks++;
      if ({out_valid, linit, lhold} !== 3'b000) begin
         errors++; $display("FAIL skp_qualify: got %b want 000", {out_valid, linit, lhold});
      end
   endtask

   task automatic test_ts1;
      drive(0, 1, 32'h000000BC, 4'h1, 1);
      checks++;
      if ({ts, linit, lhold, sdis} !== 7'b1111_1_0_0) begin
         errors++; $display("FAIL ts_word0: got %b want 1111100", {ts, linit, lhold, sdis});
      end
      drive(0, 1, 32'h4A4A0800, 4'h0, 1);
      checks++;
      if ({ts, linit, sdis} !== 6'b1111_0_1) begin
         errors++; $display("FAIL ts_word1: got %b want 111101", {ts, linit, sdis});
      end
      drive(0, 1, 32'h4A4A4A4A, 4'h0, 1);
      checks++;
      if ({ts, linit, err} !== 6'b1111_0_0) begin
         errors++; $display("FAIL ts_word2: got %b want 111100", {ts, linit, err});
      end
      drive(0, 1, 32'h45454545, 4'h0, 1);
      checks++;
      if ({ts, linit, sdis} !== 6'b1111_0_1) begin
         errors++; $display("FAIL ts_word3: got %b want 111101", {ts, linit, sdis});
      end
   endtask

   task automatic test_data;
      drive(0, 1, 32'hDEADBEEF, 4'h0, 1);
      checks++;
      if ({data, ts, linit, lhold} !== {32'hDEADBEEF, 4'h0, 2'b00}) begin
         errors++; $display("FAIL data_word: got %h want %h", {data, ts, linit, lhold}, {32'hDEADBEEF, 6'h0});
      end
   endtask

   task automatic test_com_err;
      drive(0, 1, 32'h000000BC, 4'h1, 1);
      drive(0, 1, 32'h00BC0000, 4'h4, 1);
      checks++;
      if ({err, ts, linit} !== 6'b1_0100_0) begin
         errors++; $display("FAIL com_lane2: got %b want 101000", {err, ts, linit});
      end
      drive(0, 1, 32'hDEADBEEF, 4'h0, 1);
      checks++;
      if ({err, ts} !== 5'b0_0000) begin
         errors++; $display("FAIL com_err_idle: got %b want 00000", {err, ts});
      end
      // Lane-0 COM mid-set restarts the set and flags an error.
      drive(0, 1, 32'h000000BC, 4'h1, 1);
      drive(0, 1, 32'h00000000, 4'h0, 1);
      drive(0, 1, 32'h000000BC, 4'h1, 1);
      checks++;
      if ({err, ts, linit, lhold} !== 7'b1_1111_1_0) begin
         errors++; $display("FAIL com0_restart: got %b want 1111110", {err, ts, linit, lhold});
      end
      drive(0, 1, 32'h00000000, 4'h0, 1);
      checks++;
      if ({err, ts} !== 5'b0_1111) begin
         errors++; $display("FAIL com0_restart_next: got %b want 01111", {err, ts});
      end
      drive(0, 1, 32'h0, 4'h0, 1);
      drive(0, 1, 32'h0, 4'h0, 1);
   endtask

   task automatic test_backpressure;
      drive(0, 1, 32'h11223344, 4'h0, 1);
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 32'h55667788, 4'h2, 0);
         checks++;
         if ({in_ready, out_valid, data, dk} !== {2'b01, 32'h11223344, 4'h0}) begin
            errors++; $display("FAIL bp_hold%0d: got %h want %h", i, {in_ready, out_valid, data, dk},
                               {2'b01, 32'h11223344, 4'h0});
         end
      end
      drive(0, 1, 32'h55667788, 4'h2, 1);
      checks++;
      if ({out_valid, data, dk} !== {1'b1, 32'h55667788, 4'h2}) begin
         errors++; $display("FAIL bp_release: got %h want %h", {out_valid, data, dk}, {1'b1, 32'h55667788, 4'h2});
      end
      drive(0, 0, 32'h0, 4'h0, 1);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_single: got %b want 0", out_valid);
      end
   endtask

   task automatic test_reset_mid_ts;
      drive(0, 1, 32'h000000BC, 4'h1, 1);
      drive(0, 1, 32'h00000800, 4'h0, 1);
      drive(1, 0, 32'h0, 4'h0, 1);
      drive(0, 1, 32'hCAFEF00D, 4'h0, 1);
      checks++;
      if ({ts, sdis, err} !== 6'b0) begin
         errors++; $display("FAIL reset_mid_ts: got %b want 000000", {ts, sdis, err});
      end
`ifdef SCR_CTRL_STATS_EN
      checks++;
      if (ts_cnt !== 16'h0) begin
         errors++; $display("FAIL reset_ts_cnt: got %h want 0", ts_cnt);
      end
`endif
   endtask

   task automatic test_random;
      logic [31:0] d;
      logic [3:0]  k;
      for (int n = 0; n < 400; n++) begin
         d = $urandom; k = 4'($urandom);
         case ($urandom_range(0, 5))
            0: begin d[15:0] = 16'h1CBC; k[1:0] = 2'b11; end
            1: begin d[7:0] = 8'hBC; k[0] = 1'b1; end
            2: begin d[8*$urandom_range(1, 3) +: 8] = 8'hBC; k = 4'hF; end
            default: ;
         endcase
         drive(0, ($urandom_range(0, 3) != 0), d, k, ($urandom_range(0, 3) != 0));
         checks++;
         if ({in_ready, out_valid, data, dk, ts, linit, lhold, sdis, err, dlen} !==
             {(!m_ov || out_ready), m_ov, m_data, m_k, m_ts, m_ov & m_init, m_ov & m_hold, m_dis, m_err, 2'b10}) begin
            errors++;
            $display("FAIL random[%0d]: got %h want %h", n,
                     {in_ready, out_valid, data, dk, ts, linit, lhold, sdis, err, dlen},
                     {(!m_ov || out_ready), m_ov, m_data, m_k, m_ts, m_ov & m_init, m_ov & m_hold, m_dis, m_err, 2'b10});
         end
`ifdef SCR_CTRL_STATS_EN
         checks++;
         if ({ts_cnt, skp_cnt} !== {16'(m_tsc), 16'(m_skc)}) begin
            errors++; $display("FAIL random_stats[%0d]: got %h want %h", n, {ts_cnt, skp_cnt}, {16'(m_tsc), 16'(m_skc)});
         end
`endif
      end
   endtask

   initial begin
      test_reset;
      test_skp;
      test_ts1;
      test_data;
      test_com_err;
      test_backpressure;
      test_reset_mid_ts;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/scrambler_ctrl.md
SCRAMBLER_CTRL -- requirements
Module: scrambler_ctrl

Interface
- REQ-001 Parameter LFSR_SEED, default 16'hFFFF: LFSR value the scrambler reloads when lfsr_init_o is asserted.
- REQ-002 clk_i  input  1  single clock; all logic on the rising edge.
- REQ-003 rst_i  input  1  reset; synchronous and active-high.
- REQ-004 in_valid_i / in_ready_o  input / output  1 each  upstream handshake.
- REQ-005 indata_i  input  32  four symbols; byte 0 is the earliest symbol.
- REQ-006 datak_i  input  4  per-byte K flag.
- REQ-007 out_valid_o / out_ready_i  output / input  1 each  handshake toward the scrambler.
- REQ-008 data_o  output  32  registered copy of indata_i.
- REQ-009 datak_o  output  4  registered copy of datak_i.
- REQ-010 training_sequence_o  output  4  per-byte "do not scramble" mask.
- REQ-011 data_len_o  output  2  constant 2'b10 (full word).
- REQ-012 lfsr_init_o  output  1  scrambler reloads LFSR_SEED before this word.
- REQ-013 lfsr_hold_o  output  1  scrambler does not advance its LFSR for this word.
- REQ-014 scr_disable_o  output  1  latched scrambling-disable request.
- REQ-015 err_o  output  1  one-cycle pulse on a framing error.

Function
- REQ-016 Latency: single output register stage, one cycle; in_ready_o = !out_valid_o | out_ready_i.
- REQ-017 A word transfers on in_valid_i & in_ready_o; output fields are held stable while out_valid_o & !out_ready_i.
- REQ-018 COM is datak=1 with byte 8'hBC; SKP is datak=1 with byte 8'h1C.
- REQ-019 FSM states: IDLE, TS1W, TS2W, TS3W; the state advances only on an accepted word.
- REQ-020 IDLE, COM in lane 0 and SKP in lane 1:
  - SKP word; training_sequence=4'hF, lfsr_init=1, lfsr_hold=1;
  - stay in IDLE.
- REQ-021 IDLE, COM in lane 0 and lane 1 not SKP:
  - TS word 0; training_sequence=4'hF, lfsr_init=1, lfsr_hold=0;
  - go to TS1W.
- REQ-022 TS1W, TS2W: training_sequence=4'hF; advance to TS2W and TS3W respectively.
- REQ-023 TS3W: training_sequence=4'hF; return to IDLE.
- REQ-024 In TS1W, scr_disable_o is loaded from indata_i[11] (symbol 5, bit 3); the value is visible with that word's output.
- REQ-025 IDLE, non-COM word: training_sequence = datak_i, lfsr_init=0, lfsr_hold=0.
- REQ-026 COM in lanes 1-3 in any state:
  - err_o pulses; training_sequence = datak_i;
  - FSM goes to IDLE.
- REQ-027 COM in lane 0 while in TS1W to TS3W:
  - err_o pulses;
  - the word is re-evaluated as an IDLE start per REQ-020/021.
- REQ-028 lfsr_init_o and lfsr_hold_o are qualified with out_valid_o; they are 0 when out_valid_o=0.

Reset
- REQ-029 On rst_i the FSM goes to IDLE.
- REQ-030 On rst_i: out_valid_o=0, data_o=0, datak_o=0, training_sequence_o=0, lfsr_init_o=0, lfsr_hold_o=0, scr_disable_o=0, err_o=0.
- REQ-031 Reset mid-TS discards the partial ordered set; the word presented in the cycle after reset is treated as being in IDLE.

Configuration
- REQ-032 Macro SCR_CTRL_STATS_EN, when defined, adds:
  - outputs ts_cnt_o[15:0] and skp_cnt_o[15:0];
  - they count accepted TS word-0 and SKP words respectively;
  - the counters saturate at 16'hFFFF and clear on rst_i.
- REQ-033 Without SCR_CTRL_STATS_EN, neither port nor counter logic exists and the behaviour is otherwise identical.

Structure
- REQ-034 Package scrambler_pkg holds:
  - constants K_COM=8'hBC and K_SKP=8'h1C;
  - the FSM state typedef;
  - LFSR_SEED_DEFAULT=16'hFFFF.
- REQ-035 There is one sub-module, os_detect: combinational COM/SKP lane classification of one word.

Verification
- REQ-036 Directed scenarios:
  - Reset, then word 32'h1C1C1CBC with datak=4'hF: next cycle out_valid=1, training_sequence=4'hF, lfsr_init=1, lfsr_hold=1.
  - TS1 of four words (word0 32'h000000BC, datak=4'h1; word1 byte1 bit3=1): training_sequence=4'hF for all four words, lfsr_init on word0 only, scr_disable_o=1 from word1.
  - Data word 32'hDEADBEEF, datak=0: training_sequence=0, lfsr_init=0, lfsr_hold=0, data_o=32'hDEADBEEF.
  - COM in lane 2 (datak=4'h4, byte2=8'hBC): err_o one-cycle pulse, FSM in IDLE.
  - out_ready_i=0 for 3 cycles with a word held: in_ready_o=0 and outputs stable; on release, exactly one transfer.
  - rst_i asserted after TS word1: following data word gets training_sequence=0; with SCR_CTRL_STATS_EN, ts_cnt_o=0.
